timer_dev: RTL and testbench

// - Memory-mapped countdown timer. It is the responder on the CPU's M-stage load/store

---
 rtl/timer_dev_if.sv | 25 ++
 rtl/timer_dev.sv | 188 ++++++++++++++++++
 tb/tb_timer_dev.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_if.sv
// timer_dev_if: word-wide load/store bus between the bridge (master) and the
// countdown timer (slave). The bridge has already decoded the device address.
interface timer_dev_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (
    output we,
    output addr,
    output wd,
    input  rd,
    input  irq
  );

  modport slave (
    input  we,
    input  addr,
    input  wd,
    output rd,
    output irq
  );
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes.
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 reserved.
// Reads are combinational from addr; writes land on the next rising edge.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       ctrl_r;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] count_r;
  logic             flag_r;

  logic             ctrl_en_s;
  logic [1:0]       mode_s;
  logic             im_s;
  logic             wr_ctrl_s;
  logic             wr_preset_s;

  // datapath controls decoded from the current state
  logic             load_s;
  logic             dec_s;
  logic             expire_s;
  logic             reload_s;
  logic             en_clr_s;

  logic [31:0]      rd_s;

  assign ctrl_en_s   = ctrl_r[0];
  assign mode_s      = ctrl_r[2:1];
  assign im_s        = ctrl_r[3];
  assign wr_ctrl_s   = bus.we & (bus.addr == 2'd0);
  assign wr_preset_s = bus.we & (bus.addr == 2'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection; the EN check in CNT takes priority over expiry
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: state_next_s = ST_CNT;
      ST_CNT: begin
        if (!ctrl_en_s) begin
          state_next_s = ST_IDLE;
        end else if (count_r > CNT_ONE) begin
          state_next_s = ST_CNT;
        end else begin
          state_next_s = ST_INT;
        end
      end
      ST_INT: begin
        // modes 2 and 3 fall back to one-shot behaviour
        if (mode_s == 2'd1) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    load_s   = 1'b0;
    dec_s    = 1'b0;
    expire_s = 1'b0;
    reload_s = 1'b0;
    en_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = 1'b0;
      ST_LOAD: load_s = 1'b1;
      ST_CNT: begin
        if (!ctrl_en_s) begin
          dec_s = 1'b0;
        end else if (count_r > CNT_ONE) begin
          dec_s = 1'b1;
        end else begin
          expire_s = 1'b1;
        end
      end
      ST_INT: begin
        if (mode_s == 2'd1) begin
          reload_s = 1'b1;
        end else begin
          en_clr_s = 1'b1;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // CTRL register; a CPU write beats the one-shot EN auto-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_r <= 4'd0;
    end else if (wr_ctrl_s) begin
      ctrl_r <= bus.wd[3:0];
    end else if (en_clr_s) begin
      ctrl_r[0] <= 1'b0;
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // PRESET register; only sampled into COUNT on entry to LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset_r <= CNT_ZERO;
    end else if (wr_preset_s) begin
      preset_r <= bus.wd[CNT_W-1:0];
    end else begin
      preset_r <= preset_r;
    end
  end

  // COUNT register: load, decrement, or park at zero on expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= CNT_ZERO;
    end else if (load_s) begin
      count_r <= preset_r;
    end else if (dec_s) begin
      count_r <= count_r - CNT_ONE;
    end else if (expire_s) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r;
    end
  end

  // Interrupt flag: expiry sets it and wins over any same-edge clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_r <= 1'b0;
    end else if (expire_s) begin
      flag_r <= 1'b1;
    end else if (wr_ctrl_s | wr_preset_s | reload_s) begin
      flag_r <= 1'b0;
    end else begin
      flag_r <= flag_r;
    end
  end

  // Zero-wait read mux, narrower registers zero-extended
  always_comb begin
    rd_s = 32'd0;
    case (bus.addr)
      2'd0: rd_s[3:0] = ctrl_r;
      2'd1: rd_s[CNT_W-1:0] = preset_r;
      2'd2: rd_s[CNT_W-1:0] = count_r;
      default: rd_s = 32'd0;
    endcase
  end

  assign bus.rd  = rd_s;
  assign bus.irq = im_s & flag_r;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed scenarios with literal expectations plus a randomized
// phase, all continuously compared against a behavioural timer model.
module tb_timer_dev;

  logic clk;
  logic rst;
  logic run;
  int   checks;
  int   failures;

  timer_dev_if bus ();

  timer_dev #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock generator
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model of the timer
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CNT  = 2;
  localparam int P_INT  = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic       en;
    logic [1:0] mode;
    logic       set_f;
    if (!rst) begin
      m_ctrl   = 4'd0;
      m_preset = 32'd0;
      m_count  = 32'd0;
      m_flag   = 1'b0;
      m_phase  = P_IDLE;
      return;
    end
    en    = m_ctrl[0];
    mode  = m_ctrl[2:1];
    set_f = 1'b0;
    case (m_phase)
      P_IDLE: if (en) m_phase = P_LOAD;
      P_LOAD: begin
        m_count = m_preset;
        m_phase = P_CNT;
      end
      P_CNT: begin
        if (!en) m_phase = P_IDLE;
        else if (m_count > 32'd1) m_count = m_count - 32'd1;
        else begin
          m_count = 32'd0;
          set_f   = 1'b1;
          m_phase = P_INT;
        end
      end
      default: begin
        if (mode == 2'd1) begin
          m_flag  = 1'b0;
          m_phase = P_LOAD;
        end else begin
          m_ctrl[0] = 1'b0;
          m_phase   = P_IDLE;
        end
      end
    endcase
    if (bus.we && bus.addr == 2'd0) begin
      m_ctrl = bus.wd[3:0];
      m_flag = 1'b0;
    end
    if (bus.we && bus.addr == 2'd1) begin
      m_preset = bus.wd;
      m_flag   = 1'b0;
    end
    if (set_f) m_flag = 1'b1;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // model advance on every edge and on asynchronous reset
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_edge();
    end
  end

  // scoreboard: DUT outputs against the model every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("sb_rd", bus.rd, model_rd(bus.addr));
        chk("sb_irq", {31'd0, bus.irq}, {31'd0, m_ctrl[3] & m_flag});
      end
    end
  end

  // run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic rd_lit(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.addr = a;
    #1;
    chk(nm, bus.rd, exp);
  endtask

  task automatic irq_lit(input logic exp, input string nm);
    chk(nm, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  // directed scenarios, then randomized traffic
  initial begin
    checks   = 0;
    failures = 0;
    run      = 1'b0;
    rst      = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.wd   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    rd_lit(2'd0, 32'd0, "reset_ctrl");
    rd_lit(2'd2, 32'd0, "reset_count");
    irq_lit(1'b0, "reset_irq");
    rst = 1'b1;
    step();

    // one-shot: PRESET=3, CTRL=0x9
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    rd_lit(2'd2, 32'd0, "os_e0");
    step(); rd_lit(2'd2, 32'd0, "os_e1");
    step(); rd_lit(2'd2, 32'd3, "os_e2");
    step(); rd_lit(2'd2, 32'd2, "os_e3");
    step(); rd_lit(2'd2, 32'd1, "os_e4");
    irq_lit(1'b0, "os_irq_e4");
    step(); rd_lit(2'd2, 32'd0, "os_e5");
    irq_lit(1'b1, "os_irq_e5");
    step(); rd_lit(2'd0, 32'h8, "os_ctrl_after");
    irq_lit(1'b1, "os_irq_held");
    wr(2'd0, 32'h8);
    irq_lit(1'b0, "os_irq_clr");

    // auto-reload: PRESET=2, CTRL=0xB
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    step();
    step(); rd_lit(2'd2, 32'd2, "ar_e2");
    step(); rd_lit(2'd2, 32'd1, "ar_e3");
    irq_lit(1'b0, "ar_irq_e3");
    step(); rd_lit(2'd2, 32'd0, "ar_e4");
    irq_lit(1'b1, "ar_irq_e4");
    step(); irq_lit(1'b0, "ar_irq_e5");
    step(); rd_lit(2'd2, 32'd2, "ar_e6");
    irq_lit(1'b0, "ar_irq_e6");
    step(); irq_lit(1'b0, "ar_irq_e7");
    step(); irq_lit(1'b1, "ar_irq_e8");
    wr(2'd0, 32'h0);
    repeat (3) step();

    // boundary: PRESET=0
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    step(); irq_lit(1'b0, "bd_irq_e2");
    step(); irq_lit(1'b1, "bd_irq_e3");
    step();
    wr(2'd0, 32'h1);
    step(); step(); step();
    irq_lit(1'b0, "bd_masked");
    step();
    rd_lit(2'd0, 32'h0, "bd_ctrl_en_clr");
    wr(2'd0, 32'h8);
    irq_lit(1'b0, "bd_im_write_clears");

    // mid-operation PRESET write
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step();
    step(); rd_lit(2'd2, 32'd10, "mo_e2");
    step(); rd_lit(2'd2, 32'd9, "mo_e3");
    wr(2'd1, 32'd2);
    rd_lit(2'd2, 32'd8, "mo_e4");
    repeat (7) step();
    rd_lit(2'd2, 32'd1, "mo_e11");
    irq_lit(1'b0, "mo_irq_e11");
    step(); rd_lit(2'd2, 32'd0, "mo_e12");
    irq_lit(1'b1, "mo_irq_e12");
    rd_lit(2'd1, 32'd2, "mo_preset");
    step();
    wr(2'd0, 32'h8);

    // EN=0 freezes COUNT; writes to 2 and 3 ignored
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (4) step();
    rd_lit(2'd2, 32'd8, "fr_e4");
    wr(2'd0, 32'h8);
    rd_lit(2'd2, 32'd7, "fr_e5");
    step(); rd_lit(2'd2, 32'd7, "fr_e6");
    step(); rd_lit(2'd2, 32'd7, "fr_e7");
    wr(2'd2, 32'd5);
    wr(2'd3, 32'd5);
    rd_lit(2'd2, 32'd7, "fr_ro");
    rd_lit(2'd3, 32'd0, "fr_rsv");
    step();
    rd_lit(2'd0, 32'h8, "fr_ctrl");
    rd_lit(2'd1, 32'd10, "fr_preset");

    // asynchronous reset mid-count
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    repeat (5) step();
    #2;
    rst = 1'b0;
    irq_lit(1'b0, "rst_irq");
    rd_lit(2'd2, 32'd0, "rst_count");
    step();
    rd_lit(2'd0, 32'd0, "rst_ctrl");
    rd_lit(2'd1, 32'd0, "rst_preset");
    step();
    rd_lit(2'd3, 32'd0, "rst_rsv");
    rst = 1'b1;
    repeat (3) step();
    rd_lit(2'd2, 32'd0, "rst_no_resume");
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(); step(); step();
    irq_lit(1'b1, "rst_resume");
    wr(2'd0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.we   = ($urandom_range(0, 7) == 0);
      bus.addr = 2'($urandom_range(0, 3));
      if (bus.addr == 2'd1) bus.wd = 32'($urandom_range(0, 6));
      else if (bus.addr == 2'd0) bus.wd = 32'($urandom_range(0, 15));
      else bus.wd = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b0;
        #4;
        rst = 1'b1;
      end
      step();
    end
    bus.we = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
